// File: rtl/song_pkg.sv
//----------------------------------------------------------------------------
// Module  : song_pkg
// Brief   : Shared types for the score player: FSM states, note codes, entry.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package song_pkg;

    localparam int SCORE_NOTE_W  = 4;
    localparam int SCORE_PITCH_W = 2;
    localparam int SCORE_LEN_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [SCORE_NOTE_W-1:0] NOTE_REST = '0;
    localparam logic [SCORE_NOTE_W-1:0] NOTE_END  = '1;

    typedef struct packed {
        logic [SCORE_NOTE_W-1:0]  note;
        logic [SCORE_PITCH_W-1:0] pitch;
        logic [SCORE_LEN_W-1:0]   length;
    } entry_t;

    function automatic entry_t mk_entry(input int n, input int p, input int l);
        entry_t e;
        e.note   = SCORE_NOTE_W'(n);
        e.pitch  = SCORE_PITCH_W'(p);
        e.length = SCORE_LEN_W'(l);
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/song_sequencer_if.sv
//----------------------------------------------------------------------------
// Module  : song_sequencer_if
// Brief   : Control/output bundle between panel logic and the score player.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface song_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int NOTE_W  = 4,
    parameter int PITCH_W = 2
);
    logic               start;
    logic               pause;
    logic               stop;
    logic               loop_en;
    logic [1:0]         tempo_sel;
    logic [NOTE_W-1:0]  note;
    logic [PITCH_W-1:0] pitch;
    logic               beat_led;
    logic               playing;
    logic               done;
    logic [ADDR_W-1:0]  index;

    modport master (
        output start, pause, stop, loop_en, tempo_sel,
        input  note, pitch, beat_led, playing, done, index
    );

    modport slave (
        input  start, pause, stop, loop_en, tempo_sel,
        output note, pitch, beat_led, playing, done, index
    );
endinterface

`default_nettype wire

// File: rtl/song_rom.sv
//----------------------------------------------------------------------------
// Module  : song_rom
// Brief   : Combinational score lookup; unlisted addresses read as END.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module song_rom
    import song_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    output entry_t            entry
);

    always_comb begin
        entry = mk_entry(int'(NOTE_END), 0, 0);
        case (addr)
            ADDR_W'(0): entry = mk_entry(3, 1, 1);
            ADDR_W'(1): entry = mk_entry(5, 2, 3);
            ADDR_W'(2): entry = mk_entry(0, 0, 2);
            ADDR_W'(3): entry = mk_entry(5, 2, 0);
            ADDR_W'(4): entry = mk_entry(5, 2, 1);
            default:    ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/song_sequencer.sv
//----------------------------------------------------------------------------
// Module  : song_sequencer
// Brief   : Tempo-driven score player with play/pause/stop, loop and END.
//           Optional NOTE_GAP_EN inserts a short silence at each note's end.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module song_sequencer
    import song_pkg::*;
#(
    parameter int BASE_DIV = 6_250_000,
    parameter int SONG_LEN = 163,
    parameter int ADDR_W   = 8,
    parameter int LEN_W    = 5,
    parameter int NOTE_W   = 4,
    parameter int PITCH_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    song_sequencer_if.slave  bus
);

    localparam int                  c_cnt_w    = $clog2(BASE_DIV);
    localparam int                  c_div_w    = c_cnt_w + 1;
    localparam logic [c_div_w-1:0]  c_base_div = c_div_w'(BASE_DIV);
    localparam logic [ADDR_W-1:0]   c_last_idx = ADDR_W'(SONG_LEN - 1);

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [LEN_W-1:0]     r_beats, w_beats_nxt;
    logic [ADDR_W-1:0]    r_index, w_index_nxt;
    logic [c_div_w-1:0]   r_div, w_div_nxt;
    logic [NOTE_W-1:0]    r_note;
    logic [PITCH_W-1:0]   r_pitch;
    logic                 r_done;

    entry_t               w_entry;
    logic [LEN_W-1:0]     w_len;
    logic [c_div_w-1:0]   w_tempo_div;
    logic                 w_is_end;
    logic                 w_tick;
    logic                 w_last_beat;
    logic                 w_finish;
    logic                 w_gap;
    logic                 w_sound;

    song_rom #(.ADDR_W(ADDR_W)) u_rom (
        .addr  (r_index),
        .entry (w_entry)
    );

    assign w_len       = (w_entry.length == '0) ? LEN_W'(1) : LEN_W'(w_entry.length);
    assign w_is_end    = (w_entry.note == NOTE_END);
    assign w_tempo_div = c_base_div >> bus.tempo_sel;
    assign w_tick      = ({1'b0, r_cnt} == (r_div - c_div_w'(1)));
    assign w_last_beat = (r_beats == (w_len - LEN_W'(1)));

`ifdef NOTE_GAP_EN
    // Silence the final quarter of the closing beat so repeated notes re-attack.
    assign w_gap = w_last_beat && ({1'b0, r_cnt} >= (r_div - (r_div >> 2)))
                   && (w_entry.note != NOTE_REST);
`else
    assign w_gap = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beats_nxt = r_beats;
        w_index_nxt = r_index;
        w_div_nxt   = r_div;
        w_finish    = 1'b0;
        if (bus.stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_beats_nxt = '0;
            w_index_nxt = '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        w_state_nxt = PLAY;
                        w_cnt_nxt   = '0;
                        w_beats_nxt = '0;
                        w_index_nxt = '0;
                        w_div_nxt   = w_tempo_div;
                    end
                end
                PAUSE: begin
                    if (bus.start) w_state_nxt = PLAY;
                end
                PLAY: begin
                    if (bus.pause) begin
                        w_state_nxt = PAUSE;
                    end else if (w_is_end) begin
                        w_finish = 1'b1;
                    end else if (w_tick) begin
                        w_cnt_nxt = '0;
                        w_div_nxt = w_tempo_div;
                        if (w_last_beat) begin
                            w_beats_nxt = '0;
                            if (r_index == c_last_idx) w_finish = 1'b1;
                            else                       w_index_nxt = r_index + ADDR_W'(1);
                        end else begin
                            w_beats_nxt = r_beats + LEN_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
            // End of song: rewind in place when looping, otherwise park in DONE.
            if (w_finish) begin
                w_cnt_nxt   = '0;
                w_beats_nxt = '0;
                if (bus.loop_en) w_index_nxt = '0;
                else             w_state_nxt = DONE;
            end
        end
    end

    assign w_sound = (r_state == PLAY) && (w_state_nxt == PLAY) && !w_is_end && !w_gap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_beats <= '0;
            r_index <= '0;
            r_div   <= c_base_div;
            r_note  <= '0;
            r_pitch <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beats <= w_beats_nxt;
            r_index <= w_index_nxt;
            r_div   <= w_div_nxt;
            r_note  <= w_sound ? NOTE_W'(w_entry.note) : '0;
            r_pitch <= w_sound ? PITCH_W'(w_entry.pitch) : '0;
            r_done  <= (r_state == PLAY) && (w_state_nxt == DONE);
        end
    end

    assign bus.note     = r_note;
    assign bus.pitch    = r_pitch;
    assign bus.index    = r_index;
    assign bus.done     = r_done;
    assign bus.playing  = (r_state == PLAY);
    assign bus.beat_led = (r_state == PLAY) && ({1'b0, r_cnt} < (r_div >> 1));

endmodule

`default_nettype wire
